// File: rtl/universal_shift_reg_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
// No logic; types and a small opcode classifier only.
// Imported by the interface, the step sub-module and the top.
package usr_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ASR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True for the opcodes that move bits (and therefore honour op_amt).
    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Command/response bundle of the universal shift register.
// Latency: n/a (wires only).
// Backpressure: op_valid/op_ready handshake; requester holds op_valid until op_ready.
// Ports: master = command requester, slave = shift register.
interface universal_shift_reg_if
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic             op_valid;
    logic             op_ready;
    op_e              op_code;
    logic [AW-1:0]    op_amt;
    logic [WIDTH-1:0] load_data;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output op_valid, op_code, op_amt, load_data, serial_in,
        input  op_ready, data_out, serial_out, busy, done
    );

    modport slave (
        input  op_valid, op_code, op_amt, load_data, serial_in,
        output op_ready, data_out, serial_out, busy, done
    );

endinterface

// File: rtl/universal_shift_reg_step.sv
// One-bit shift/rotate step of the universal shift register.
// Latency: combinational.
// Backpressure: none.
// Ports: d (current value), op, serial_in (fill bit) -> d_next, bit_out (bit leaving).
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    input  logic             serial_in,
    output logic [WIDTH-1:0] d_next,
    output logic             bit_out
);

    always_comb begin
        d_next  = d;
        bit_out = 1'b0;
        case (op)
            OP_SHL: begin
                d_next  = {d[WIDTH-2:0], serial_in};
                bit_out = d[WIDTH-1];
            end
            OP_SHR: begin
                d_next  = {serial_in, d[WIDTH-1:1]};
                bit_out = d[0];
            end
            OP_ASR: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            OP_ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                bit_out = d[WIDTH-1];
            end
            OP_ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            default: begin
                d_next  = d;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shift, rotate by N.
// Latency: done 1 cycle after accept, or N+1 for an N-bit shift (1 with USR_BARREL_EN).
// Backpressure: op_ready only in IDLE; commands are ignored while SHIFT/DONE.
// Ports: clk, rst_n (async active-low), bus (universal_shift_reg_if.slave).
// Build option USR_BARREL_EN: perform whole shifts in one cycle on the accept edge.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    universal_shift_reg_if.slave  bus
);

    localparam int            AW      = $clog2(WIDTH) + 1;
    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             sout_q,  sout_d;
    logic [AW-1:0]    amt_clamp;

    // Distances beyond the register width behave as a full-width shift.
    assign amt_clamp = (bus.op_amt > AMT_MAX) ? AMT_MAX : bus.op_amt;

`ifdef USR_BARREL_EN
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] barrel_data;
    logic             barrel_bit;

    // Whole N-bit shift in one go. Only used when amt_clamp is 1..WIDTH.
    // barrel_bit is the bit the N-th sequential step would have emitted.
    always_comb begin
        int               sh;
        logic [WIDTH-1:0] out_vec;
        sh          = int'(amt_clamp);
        barrel_data = data_q;
        out_vec     = '0;
        if (sh != 0) begin
            case (bus.op_code)
                OP_SHL: begin
                    barrel_data = (data_q << sh) | (bus.serial_in ? ~(ONES << sh) : '0);
                    out_vec     = data_q >> (WIDTH - sh);
                end
                OP_SHR: begin
                    barrel_data = (data_q >> sh) | (bus.serial_in ? ~(ONES >> sh) : '0);
                    out_vec     = data_q >> (sh - 1);
                end
                OP_ASR: begin
                    barrel_data = $unsigned($signed(data_q) >>> sh);
                    out_vec     = data_q >> (sh - 1);
                end
                OP_ROL: begin
                    barrel_data = (data_q << sh) | (data_q >> (WIDTH - sh));
                    out_vec     = data_q >> (WIDTH - sh);
                end
                OP_ROR: begin
                    barrel_data = (data_q >> sh) | (data_q << (WIDTH - sh));
                    out_vec     = data_q >> (sh - 1);
                end
                default: begin
                    barrel_data = data_q;
                    out_vec     = '0;
                end
            endcase
        end
        barrel_bit = out_vec[0];
    end
`else
    op_e              op_q,  op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    // serial_in goes straight to the step so it is sampled on every step.
    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d         (data_q),
        .op        (op_q),
        .serial_in (bus.serial_in),
        .d_next    (step_data),
        .bit_out   (step_bit)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sout_d  = sout_q;
`ifndef USR_BARREL_EN
        op_d    = op_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    // Everything that is not a non-zero shift completes via DONE directly.
                    state_d = ST_DONE;
                    if (bus.op_code == OP_LOAD) begin
                        data_d = bus.load_data;
                    end else if (is_shift(bus.op_code) && (amt_clamp != '0)) begin
`ifdef USR_BARREL_EN
                        data_d = barrel_data;
                        sout_d = barrel_bit;
`else
                        state_d = ST_SHIFT;
                        op_d    = bus.op_code;
                        cnt_d   = amt_clamp;
`endif
                    end
                end
            end
            ST_SHIFT: begin
`ifdef USR_BARREL_EN
                state_d = ST_IDLE;
`else
                data_d = step_data;
                sout_d = step_bit;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= RESET_VAL;
            sout_q  <= 1'b0;
`ifndef USR_BARREL_EN
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
`ifndef USR_BARREL_EN
            op_q    <= op_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.op_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.data_out   = data_q;
    assign bus.serial_out = sout_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5).
// Commands are pushed to a scoreboard at accept; checked when done pulses.
// Valid for both the sequential build and USR_BARREL_EN.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;
    localparam int NV = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    universal_shift_reg_if #(.WIDTH(W)) bus ();

    universal_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        op_e           op;
        logic [AW-1:0] amt;
        logic [W-1:0]  load;
        logic          sin;
        logic [W-1:0]  exp_data;
        logic          exp_sout;
        int            exp_busy;   // busy cycles in the sequential build
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         sout;
        int           busy;
        int           acc_cyc;
        string        name;
    } sb_t;

    vec_t  vecs [NV];
    sb_t   sb [$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    busy_cnt = 0;
    int    last_done_cyc = 0;
    int    last_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int eff_busy(input int b);
`ifdef USR_BARREL_EN
        return 0 * b;
`else
        return b;
`endif
    endfunction

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            sb.delete();
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"},    int'(bus.data_out),   int'(e.data));
                    chk({e.name, "_sout"},    int'(bus.serial_out), int'(e.sout));
                    chk({e.name, "_busy"},    busy_cnt,             e.busy);
                    chk({e.name, "_latency"}, cyc - e.acc_cyc,      e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    // Presents a command, waits for acceptance, records the expectation.
    // Leaves op_valid high so a following issue() is back-to-back.
    task automatic issue(input vec_t v, input string name);
        int  n;
        sb_t e;
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op_code   = v.op;
        bus.op_amt    = v.amt;
        bus.load_data = v.load;
        bus.serial_in = v.sin;
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_ready) begin
            chk({name, "_accept_timeout"}, 0, 1);
            bus.op_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.data    = v.exp_data;
            e.sout    = v.exp_sout;
            e.busy    = eff_busy(v.exp_busy);
            e.acc_cyc = cyc;
            e.name    = name;
            sb.push_back(e);
            last_gap  = cyc - last_done_cyc;
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        bus.op_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // op, amt, load, sin, exp data, exp serial_out, sequential busy cycles
        vecs[0]  = '{OP_LOAD, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b0, 0};
        vecs[1]  = '{OP_SHL,  4'd2,  8'h00, 1'b1, 8'hF3, 1'b0, 2};
        vecs[2]  = '{OP_LOAD, 4'd0,  8'h90, 1'b0, 8'h90, 1'b0, 0};
        vecs[3]  = '{OP_ASR,  4'd3,  8'h00, 1'b0, 8'hF2, 1'b0, 3};
        vecs[4]  = '{OP_LOAD, 4'd0,  8'h5A, 1'b0, 8'h5A, 1'b0, 0};
        vecs[5]  = '{OP_ROR,  4'd8,  8'h00, 1'b0, 8'h5A, 1'b0, 8};
        vecs[6]  = '{OP_LOAD, 4'd0,  8'hFF, 1'b0, 8'hFF, 1'b0, 0};
        vecs[7]  = '{OP_SHR,  4'd15, 8'h00, 1'b0, 8'h00, 1'b1, 8};
        vecs[8]  = '{OP_HOLD, 4'd0,  8'h77, 1'b0, 8'h00, 1'b1, 0};
        vecs[9]  = '{OP_SHL,  4'd0,  8'h77, 1'b1, 8'h00, 1'b1, 0};
        vecs[10] = '{OP_RSVD, 4'd3,  8'h77, 1'b1, 8'h00, 1'b1, 0};
        vecs[11] = '{OP_LOAD, 4'd0,  8'hB4, 1'b0, 8'hB4, 1'b1, 0};
        vecs[12] = '{OP_ROL,  4'd3,  8'h00, 1'b0, 8'hA5, 1'b1, 3};
        vecs[13] = '{OP_SHR,  4'd4,  8'h00, 1'b1, 8'hFA, 1'b0, 4};
        vecs[14] = '{OP_ASR,  4'd8,  8'h00, 1'b0, 8'hFF, 1'b1, 8};
        vecs[15] = '{OP_LOAD, 4'd0,  8'h81, 1'b0, 8'h81, 1'b1, 0};
        vecs[16] = '{OP_SHL,  4'd3,  8'h00, 1'b1, 8'h0F, 1'b0, 3};
        vecs[17] = '{OP_HOLD, 4'd5,  8'h00, 1'b1, 8'h0F, 1'b0, 0};
        vecs[18] = '{OP_SHL,  4'd9,  8'h00, 1'b0, 8'h00, 1'b1, 8};
        vecs[19] = '{OP_LOAD, 4'd0,  8'hC3, 1'b0, 8'hC3, 1'b1, 0};
        vecs[20] = '{OP_ROL,  4'd8,  8'h00, 1'b0, 8'hC3, 1'b1, 8};
        vecs[21] = '{OP_LOAD, 4'd0,  8'hF0, 1'b0, 8'hF0, 1'b1, 0};
        vecs[22] = '{OP_SHR,  4'd1,  8'h00, 1'b0, 8'h78, 1'b0, 1};

        bus.op_valid  = 1'b0;
        bus.op_code   = OP_HOLD;
        bus.op_amt    = '0;
        bus.load_data = '0;
        bus.serial_in = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  int'(bus.data_out),   32'hA5);
        chk("rst_sout",  int'(bus.serial_out), 0);
        chk("rst_ready", int'(bus.op_ready),   1);
        chk("rst_busy",  int'(bus.busy),       0);
        chk("rst_done",  int'(bus.done),       0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], $sformatf("v%0d", i));
            drain();
        end

        // Held op_valid: second command waits for IDLE, one bubble after done.
        v = '{OP_LOAD, 4'd0, 8'hF0, 1'b0, 8'hF0, 1'b0, 0};
        issue(v, "held_load");
        drain();
        v = '{OP_SHR, 4'd4, 8'h00, 1'b0, 8'h0F, 1'b0, 4};
        issue(v, "held_first");
        @(negedge clk);
        bus.op_code = OP_HOLD;
        bus.op_amt  = '0;
        chk("held_not_ready", int'(bus.op_ready), 0);
        chk("held_busy",      int'(bus.busy),     eff_busy(1));
        v = '{OP_HOLD, 4'd0, 8'h00, 1'b0, 8'h0F, 1'b0, 0};
        issue(v, "held_second");
        chk("held_gap", last_gap, 2);
        drain();

        // Prime serial_out=1, then reset in the middle of a shift.
        v = '{OP_SHR, 4'd1, 8'h00, 1'b0, 8'h07, 1'b1, 1};
        issue(v, "pre_rst");
        drain();
        v = '{OP_SHR, 4'd5, 8'h00, 1'b0, 8'h00, 1'b1, 5};
        issue(v, "aborted");
        @(negedge clk);
        chk("rst_mid_busy_before", int'(bus.busy), eff_busy(1));
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("rst_mid_data",  int'(bus.data_out),   32'hA5);
        chk("rst_mid_sout",  int'(bus.serial_out), 0);
        chk("rst_mid_busy",  int'(bus.busy),       0);
        chk("rst_mid_done",  int'(bus.done),       0);
        chk("rst_mid_ready", int'(bus.op_ready),   1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        v = '{OP_ROR, 4'd1, 8'h00, 1'b0, 8'hD2, 1'b1, 1};
        issue(v, "post_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
